// File: rtl/seg_display_pkg.sv
// Shared types and constants for the multiplexed seven-segment display slice.
package seg_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_GUARD = 2'd2
    } scan_state_t;

    localparam int unsigned NUM_DIGITS = 4;
    localparam logic [3:0]  BLANK_CODE = 4'hF;
    localparam logic [6:0]  SEG_OFF    = 7'b1111111;
    localparam logic [NUM_DIGITS-1:0] AN_OFF = '1;

    // Active-low one-hot anode pattern for the given digit index.
    function automatic logic [NUM_DIGITS-1:0] an_select(input logic [1:0] idx);
        logic [NUM_DIGITS-1:0] an;
        an      = AN_OFF;
        an[idx] = 1'b0;
        return an;
    endfunction

endpackage

// File: rtl/seven_segment_decoder.sv
// BCD digit to active-low {g,f,e,d,c,b,a} segment pattern; codes 10..15 are blank.
module seven_segment_decoder
    import seg_display_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        unique case (digit_i)
            4'd0:    seg_o = 7'b1000000;
            4'd1:    seg_o = 7'b1111001;
            4'd2:    seg_o = 7'b0100100;
            4'd3:    seg_o = 7'b0110000;
            4'd4:    seg_o = 7'b0011001;
            4'd5:    seg_o = 7'b0010010;
            4'd6:    seg_o = 7'b0000010;
            4'd7:    seg_o = 7'b1111000;
            4'd8:    seg_o = 7'b0000000;
            4'd9:    seg_o = 7'b0010000;
            default: seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seven_segment_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with guard gaps, shadowed value
// updates at frame boundaries and optional leading-zero blanking.
module seven_segment_scan_ctrl
    import seg_display_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned GUARD_CYC = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] value_in,
    input  logic [3:0]  dp_in,
    input  logic        lz_en,
    output logic        ready,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam logic [19:0] PRESC_LAST = 20'(SCAN_DIV - 1);
    localparam logic [7:0]  GUARD_LAST = 8'(GUARD_CYC - 1);

    scan_state_t state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [19:0] presc_q, presc_d;
    logic [7:0]  guard_q, guard_d;

    logic [15:0] shadow_val_q, active_val_q;
    logic [3:0]  shadow_dp_q, active_dp_q;
    logic        pending_q;

    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;

    logic       frame_start, commit, accept;
    logic [3:0] nibble, code;
    logic       z3, z2, z1, blank_lz;
    logic [6:0] dec_seg;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        presc_d = presc_q;
        guard_d = guard_q;
        if (!enable) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            presc_d = '0;
            guard_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_SHOW;
                    idx_d   = '0;
                    presc_d = '0;
                end
                ST_SHOW: begin
                    if (presc_q == PRESC_LAST) begin
                        state_d = ST_GUARD;
                        presc_d = '0;
                        guard_d = '0;
                    end else begin
                        presc_d = presc_q + 20'd1;
                    end
                end
                ST_GUARD: begin
                    if (guard_q == GUARD_LAST) begin
                        state_d = ST_SHOW;
                        idx_d   = idx_q + 2'd1;
                        guard_d = '0;
                    end else begin
                        guard_d = guard_q + 8'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Commit lands on the same edge that enters SHOW at digit 0, so the whole
    // frame is drawn from one value.
    assign frame_start = (state_d == ST_SHOW) && (idx_d == 2'd0) && (state_q != ST_SHOW);
    assign commit      = pending_q && ((state_q == ST_IDLE) || frame_start);
    assign accept      = load && !pending_q;
    assign ready       = ~pending_q;

    always_comb begin
        nibble   = active_val_q[{idx_q, 2'b00} +: 4];
        z3       = (active_val_q[15:12] == 4'h0);
        z2       = z3 && (active_val_q[11:8] == 4'h0);
        z1       = z2 && (active_val_q[7:4] == 4'h0);
        blank_lz = 1'b0;
        unique case (idx_q)
            2'd1:    blank_lz = z1;
            2'd2:    blank_lz = z2;
            2'd3:    blank_lz = z3;
            default: blank_lz = 1'b0;
        endcase
        code = (lz_en && blank_lz) ? BLANK_CODE : nibble;
    end

    seven_segment_decoder u_decoder (
        .digit_i (code),
        .seg_o   (dec_seg)
    );

    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (state_q == ST_SHOW) begin
            an_d  = an_select(idx_q);
            seg_d = dec_seg;
            dp_d  = ~active_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            presc_q      <= '0;
            guard_q      <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            active_val_q <= '0;
            active_dp_q  <= '0;
            pending_q    <= 1'b0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
            dp_q         <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            presc_q <= presc_d;
            guard_q <= guard_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            if (commit) begin
                active_val_q <= shadow_val_q;
                active_dp_q  <= shadow_dp_q;
                pending_q    <= 1'b0;
            end else if (accept) begin
                shadow_val_q <= value_in;
                shadow_dp_q  <= dp_in;
                pending_q    <= 1'b1;
            end
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seven_segment_scan_ctrl.sv
// Directed bench for seven_segment_scan_ctrl with SCAN_DIV=4, GUARD_CYC=1.
module tb_seven_segment_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset, enable, load, lz_en;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic        ready;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int checks   = 0;
    int failures = 0;

    localparam logic [11:0] DARK = {4'b1111, 7'b1111111, 1'b1};

    seven_segment_scan_ctrl #(.SCAN_DIV(4), .GUARD_CYC(1)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .load     (load),
        .value_in (value_in),
        .dp_in    (dp_in),
        .lz_en    (lz_en),
        .ready    (ready),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] dec7(input logic [3:0] n);
        case (n)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Expected {an,seg,dp} at sample c after the first enabled edge (c=1):
    // 4 lit cycles then 1 guard cycle per digit, one cycle of output latency.
    function automatic logic [11:0] model(input int c, input logic [15:0] val,
                                          input logic [3:0] dpv, input logic lz);
        int p, d;
        logic [3:0] nib, anv;
        logic blk;
        if (c < 2) return DARK;
        p = (c - 2) % 5;
        d = ((c - 2) / 5) % 4;
        if (p == 4) return DARK;
        nib = val[d*4 +: 4];
        blk = lz && (d != 0);
        for (int k = d; k < 4; k++) if (val[k*4 +: 4] != 4'h0) blk = 1'b0;
        anv = 4'b1111;
        anv[d] = 1'b0;
        return {anv, blk ? 7'b1111111 : dec7(nib), ~dpv[d]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        enable = 1'b0;
        tick();
        tick();
    endtask

    task automatic idle_load(input logic [15:0] v, input logic [3:0] d);
        value_in = v;
        dp_in    = d;
        load     = 1'b1;
        tick();
        load     = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; load = 1'b1;
        value_in = 16'hFFFF; dp_in = 4'hF; lz_en = 1'b0;
        tick();
        tick();
        checks++;
        if ({ready, an, seg, dp} !== {1'b1, DARK}) begin
            failures++;
            $display("FAIL reset_outputs got ready=%b an=%b seg=%b dp=%b exp ready=1 an=1111 seg=1111111 dp=1",
                     ready, an, seg, dp);
        end
        reset = 1'b0; load = 1'b0; enable = 1'b0;
        tick();
        checks++;
        if ({ready, an, seg, dp} !== {1'b1, DARK}) begin
            failures++;
            $display("FAIL reset_priority got ready=%b an=%b seg=%b dp=%b exp ready=1 dark",
                     ready, an, seg, dp);
        end
    endtask

    task automatic test_scan_1234();
        logic [11:0] exp;
        value_in = 16'h1234; dp_in = 4'b0000; load = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("FAIL idle_load_pending got ready=%b exp 0", ready);
        end
        tick();
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL idle_commit got ready=%b exp 1", ready);
        end
        enable = 1'b1;
        for (int c = 1; c <= 41; c++) begin
            tick();
            exp = model(c, 16'h1234, 4'b0000, 1'b0);
            checks++;
            if ({an, seg, dp} !== exp) begin
                failures++;
                $display("FAIL scan_1234 c=%0d got %b_%b_%b exp %b", c, an, seg, dp, exp);
            end
        end
        go_idle();
    endtask

    task automatic test_lz_blank();
        logic [11:0] exp;
        logic [15:0] vals [2];
        vals[0] = 16'h0070;
        vals[1] = 16'h0000;
        lz_en = 1'b1;
        for (int v = 0; v < 2; v++) begin
            idle_load(vals[v], 4'b0000);
            enable = 1'b1;
            for (int c = 1; c <= 21; c++) begin
                tick();
                exp = model(c, vals[v], 4'b0000, 1'b1);
                checks++;
                if ({an, seg, dp} !== exp) begin
                    failures++;
                    $display("FAIL lz_blank val=%h c=%0d got %b_%b_%b exp %b",
                             vals[v], c, an, seg, dp, exp);
                end
            end
            go_idle();
        end
        lz_en = 1'b0;
    endtask

    task automatic test_blank_codes_dp();
        logic [11:0] exp;
        idle_load(16'hABCF, 4'b0001);
        enable = 1'b1;
        for (int c = 1; c <= 21; c++) begin
            tick();
            exp = model(c, 16'hABCF, 4'b0001, 1'b0);
            checks++;
            if ({an, seg, dp} !== exp) begin
                failures++;
                $display("FAIL blank_dp c=%0d got %b_%b_%b exp %b", c, an, seg, dp, exp);
            end
        end
        go_idle();
    endtask

    task automatic test_midframe_load();
        logic [11:0] exp;
        idle_load(16'h1234, 4'b0000);
        enable = 1'b1;
        for (int c = 1; c <= 41; c++) begin
            tick();
            exp = model(c, (c <= 21) ? 16'h1234 : 16'h5555, 4'b0000, 1'b0);
            checks++;
            if ({an, seg, dp} !== exp) begin
                failures++;
                $display("FAIL midframe_display c=%0d got %b_%b_%b exp %b", c, an, seg, dp, exp);
            end
            if (c == 12 || c >= 21) begin
                checks++;
                if (ready !== 1'b1) begin
                    failures++;
                    $display("FAIL midframe_ready_high c=%0d got %b exp 1", c, ready);
                end
            end else if (c >= 13 && c <= 20) begin
                checks++;
                if (ready !== 1'b0) begin
                    failures++;
                    $display("FAIL midframe_ready_low c=%0d got %b exp 0", c, ready);
                end
            end
            if (c == 12) begin
                value_in = 16'h5555; load = 1'b1;
            end else if (c == 13) begin
                value_in = 16'h9999;
            end else if (c == 14) begin
                load = 1'b0;
            end
        end
        go_idle();
    endtask

    task automatic test_enable_drop();
        logic [11:0] exp;
        enable = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            tick();
            exp = (c <= 9) ? model(c, 16'h5555, 4'b0000, 1'b0) : DARK;
            checks++;
            if ({an, seg, dp} !== exp) begin
                failures++;
                $display("FAIL enable_drop c=%0d got %b_%b_%b exp %b", c, an, seg, dp, exp);
            end
            if (c == 8) enable = 1'b0;
        end
        enable = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            tick();
            exp = model(c, 16'h5555, 4'b0000, 1'b0);
            checks++;
            if ({an, seg, dp} !== exp) begin
                failures++;
                $display("FAIL reenable c=%0d got %b_%b_%b exp %b", c, an, seg, dp, exp);
            end
        end
        go_idle();
    endtask

    task automatic test_reset_in_guard();
        logic [11:0] exp;
        enable = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 4) begin
                load = 1'b0;
                checks++;
                if (ready !== 1'b0) begin
                    failures++;
                    $display("FAIL guard_pending got ready=%b exp 0", ready);
                end
            end
            if (c == 3) begin
                value_in = 16'h8888; load = 1'b1;
            end
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({ready, an, seg, dp} !== {1'b1, DARK}) begin
            failures++;
            $display("FAIL guard_reset got ready=%b an=%b seg=%b dp=%b exp ready=1 dark",
                     ready, an, seg, dp);
        end
        reset = 1'b0;
        for (int c = 1; c <= 21; c++) begin
            tick();
            exp = model(c, 16'h0000, 4'b0000, 1'b0);
            checks++;
            if ({ready, an, seg, dp} !== {1'b1, exp}) begin
                failures++;
                $display("FAIL post_reset c=%0d got ready=%b %b_%b_%b exp ready=1 %b",
                         c, ready, an, seg, dp, exp);
            end
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_scan_1234();
        test_lz_blank();
        test_blank_codes_dp();
        test_midframe_load();
        test_enable_drop();
        test_reset_in_guard();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
